// File: rtl/thunderbird_pkg.sv
// Shared definitions for the turn-signal lamp subsystem: state encodings,
// lamp pattern constants, error codes and the lamp-pattern classifier.
package thunderbird_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_R1   = 3'd4,
        ST_R2   = 3'd5,
        ST_R3   = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_1 = 3'b100;
    localparam logic [2:0] LAMP_2 = 3'b110;
    localparam logic [2:0] LAMP_3 = 3'b111;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_BOTH  = 3'd1;
    localparam logic [2:0] ERR_BAD   = 3'd2;
    localparam logic [2:0] ERR_ORDER = 3'd3;

    typedef enum logic [3:0] {
        PAT_OFF, PAT_L1, PAT_L2, PAT_L3, PAT_R1, PAT_R2, PAT_R3, PAT_BOTH, PAT_BAD
    } pattern_t;

    function automatic pattern_t classify(input logic [2:0] left, input logic [2:0] right);
        pattern_t   pat;
        logic       is_left;
        is_left = (left != 3'b000);
        if (left == 3'b000 && right == 3'b000)
            pat = PAT_OFF;
        else if (left != 3'b000 && right != 3'b000)
            pat = PAT_BOTH;
        else begin
            case (left | right)
                LAMP_1:  pat = is_left ? PAT_L1 : PAT_R1;
                LAMP_2:  pat = is_left ? PAT_L2 : PAT_R2;
                LAMP_3:  pat = is_left ? PAT_L3 : PAT_R3;
                default: pat = PAT_BAD;
            endcase
        end
        return pat;
    endfunction

    // The state a sample resynchronises to; also the legal successor whenever
    // the sample is legal, since every legal step lands on the sampled pattern.
    function automatic state_t pattern_state(input pattern_t pat);
        case (pat)
            PAT_L1:  return ST_L1;
            PAT_L2:  return ST_L2;
            PAT_L3:  return ST_L3;
            PAT_R1:  return ST_R1;
            PAT_R2:  return ST_R2;
            PAT_R3:  return ST_R3;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] dir_of(input state_t s);
        case (s)
            ST_L1, ST_L2, ST_L3: return 2'b01;
            ST_R1, ST_R2, ST_R3: return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/thunderbird_decoder.sv
// Lamp-bus monitor: decodes the six tail lamps back into turn sequences,
// pulses on completion or protocol violation and counts both.
module thunderbird_decoder
    import thunderbird_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             LA,
    input  logic             LB,
    input  logic             LC,
    input  logic             RA,
    input  logic             RB,
    input  logic             RC,
    output logic [1:0]       active_dir,
    output logic             left_done,
    output logic             right_done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count,
    output logic [CNT_W-1:0] err_count
);

    state_t     state;
    state_t     nxt;
    pattern_t   pat;
    logic       legal;
    logic       left_inc;
    logic       right_inc;
    logic       err_inc;
    logic [2:0] code;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        pat   = classify({LA, LB, LC}, {RA, RB, RC});
        legal = 1'b0;
        code  = ERR_ORDER;
        case (state)
            ST_IDLE:      legal = (pat inside {PAT_OFF, PAT_L1, PAT_R1});
            ST_L1:        legal = (pat == PAT_L2);
            ST_L2:        legal = (pat == PAT_L3);
            ST_R1:        legal = (pat == PAT_R2);
            ST_R2:        legal = (pat == PAT_R3);
            ST_L3, ST_R3: legal = (pat == PAT_OFF);
            default:      legal = 1'b0;
        endcase
        if (pat == PAT_BOTH)
            code = ERR_BOTH;
        else if (pat == PAT_BAD)
            code = ERR_BAD;
        left_inc  = sample_en && state == ST_L3 && pat == PAT_OFF;
        right_inc = sample_en && state == ST_R3 && pat == PAT_OFF;
        err_inc   = sample_en && !legal;
        nxt       = sample_en ? pattern_state(pat) : state;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            active_dir <= 2'b00;
            left_done  <= 1'b0;
            right_done <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= nxt;
            active_dir <= dir_of(nxt);
            left_done  <= left_inc;
            right_done <= right_inc;
            err        <= err_inc;
            if (err_inc)
                err_code <= code;
        end
    end

    sat_counter #(.W(CNT_W)) u_left_count (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (left_inc),
        .count (left_count)
    );

    sat_counter #(.W(CNT_W)) u_right_count (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (right_inc),
        .count (right_count)
    );

    sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_thunderbird_decoder.sv
// Bench for thunderbird_decoder: a default-width and a 2-bit-counter instance
// share one stimulus stream and are compared against a side/step model.
module tb_thunderbird_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b0;
    logic [2:0] left_lamps = 3'b000;
    logic [2:0] right_lamps = 3'b000;

    logic [1:0] dir8, dir2;
    logic       ld8, rd8, er8, ld2, rd2, er2;
    logic [2:0] code8, code2;
    logic [7:0] lc8, rc8, ec8;
    logic [1:0] lc2, rc2, ec2;

    int errors = 0;
    int checks = 0;

    // Model: side 0 none / 1 left / 2 right, step 0..3 lamps lit
    int m_side = 0, m_step = 0;
    int m_lc = 0, m_rc = 0, m_ec = 0;
    int m_ld = 0, m_rd = 0, m_er = 0, m_code = 0;

    int ld_seen = 0, err_seen = 0;

    always #5 clk = ~clk;

    thunderbird_decoder #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .LA(left_lamps[2]), .LB(left_lamps[1]), .LC(left_lamps[0]),
        .RA(right_lamps[2]), .RB(right_lamps[1]), .RC(right_lamps[0]),
        .active_dir(dir8), .left_done(ld8), .right_done(rd8), .err(er8),
        .err_code(code8), .left_count(lc8), .right_count(rc8), .err_count(ec8)
    );

    thunderbird_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .LA(left_lamps[2]), .LB(left_lamps[1]), .LC(left_lamps[0]),
        .RA(right_lamps[2]), .RB(right_lamps[1]), .RC(right_lamps[0]),
        .active_dir(dir2), .left_done(ld2), .right_done(rd2), .err(er2),
        .err_code(code2), .left_count(lc2), .right_count(rc2), .err_count(ec2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lit_count(input logic [2:0] v);
        // Lamps light from the inside out: 100, 110, 111; anything else is -1
        if (v == 3'b000) return 0;
        if (v == 3'b100) return 1;
        if (v == 3'b110) return 2;
        if (v == 3'b111) return 3;
        return -1;
    endfunction

    function automatic int sat(input int v, input int bits);
        int top = (1 << bits) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_step(input logic en, input logic [2:0] l, input logic [2:0] r);
        int t_side, t_step;
        bit ok;
        m_ld = 0; m_rd = 0; m_er = 0;
        if (!en) return;
        if (l != 0 && r != 0) begin
            m_er = 1; m_code = 1; m_side = 0; m_step = 0;
        end else begin
            t_side = (l != 0) ? 1 : (r != 0) ? 2 : 0;
            t_step = lit_count(l | r);
            if (t_step < 0) begin
                m_er = 1; m_code = 2; m_side = 0; m_step = 0;
            end else begin
                if (t_side == 0)
                    ok = (m_step == 0) || (m_step == 3);
                else
                    ok = (m_side == 0 && t_step == 1) ||
                         (m_side == t_side && t_step == m_step + 1);
                if (t_side == 0 && m_step == 3) begin
                    if (m_side == 1) begin m_ld = 1; m_lc++; end
                    else             begin m_rd = 1; m_rc++; end
                end
                if (!ok) begin m_er = 1; m_code = 3; end
                m_side = t_side;
                m_step = t_step;
            end
        end
        if (m_er != 0) m_ec++;
    endtask

    task automatic compare_all();
        check("dir", dir8, m_side);
        check("left_done", ld8, m_ld);
        check("right_done", rd8, m_rd);
        check("err", er8, m_er);
        check("err_code", code8, m_code);
        check("left_count", lc8, sat(m_lc, 8));
        check("right_count", rc8, sat(m_rc, 8));
        check("err_count", ec8, sat(m_ec, 8));
        check("w2 dir", dir2, m_side);
        check("w2 pulses", {ld2, rd2, er2}, {m_ld[0], m_rd[0], m_er[0]});
        check("w2 err_code", code2, m_code);
        check("w2 left_count", lc2, sat(m_lc, 2));
        check("w2 right_count", rc2, sat(m_rc, 2));
        check("w2 err_count", ec2, sat(m_ec, 2));
    endtask

    task automatic apply(input logic en, input logic [2:0] l, input logic [2:0] r);
        sample_en = en;
        left_lamps = l;
        right_lamps = r;
        @(posedge clk);
        #1;
        model_step(en, l, r);
        compare_all();
        if (ld8) ld_seen++;
        if (er8) err_seen++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dir"}, dir8, 0);
        check({tag, " pulses"}, {ld8, rd8, er8}, 0);
        check({tag, " err_code"}, code8, 0);
        check({tag, " counts"}, {lc8, rc8, ec8}, 0);
        check({tag, " w2 counts"}, {lc2, rc2, ec2}, 0);
    endtask

    task automatic model_reset();
        m_side = 0; m_step = 0; m_lc = 0; m_rc = 0; m_ec = 0;
        m_ld = 0; m_rd = 0; m_er = 0; m_code = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [2:0] l;
        logic [2:0] r;
        logic [1:0] dir;
        logic       ld;
        logic       rd;
        logic       er;
        logic [2:0] code;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs = '{
            '{1, 3'b000, 3'b000, 2'b00, 0, 0, 0, 3'd0},
            '{1, 3'b100, 3'b000, 2'b01, 0, 0, 0, 3'd0},
            '{1, 3'b110, 3'b000, 2'b01, 0, 0, 0, 3'd0},
            '{1, 3'b111, 3'b000, 2'b01, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b000, 2'b00, 1, 0, 0, 3'd0},
            '{1, 3'b000, 3'b100, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b110, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b111, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b000, 2'b00, 0, 1, 0, 3'd0},
            '{1, 3'b000, 3'b100, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b110, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b111, 2'b10, 0, 0, 0, 3'd0},
            '{1, 3'b000, 3'b000, 2'b00, 0, 1, 0, 3'd0},
            '{1, 3'b100, 3'b000, 2'b01, 0, 0, 0, 3'd0},
            '{1, 3'b111, 3'b000, 2'b01, 0, 0, 1, 3'd3},
            '{1, 3'b000, 3'b000, 2'b00, 1, 0, 0, 3'd3},
            '{1, 3'b010, 3'b000, 2'b00, 0, 0, 1, 3'd2},
            '{1, 3'b100, 3'b100, 2'b00, 0, 0, 1, 3'd1},
            '{1, 3'b000, 3'b000, 2'b00, 0, 0, 0, 3'd1}
        };

        #12;
        check_zero("reset");
        release_reset();

        // Directed table: left, two rights, order violation, illegal patterns
        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d dir", i), dir8, vecs[i].dir);
            check($sformatf("vec%0d pulses", i), {ld8, rd8, er8}, {vecs[i].ld, vecs[i].rd, vecs[i].er});
            check($sformatf("vec%0d err_code", i), code8, vecs[i].code);
        end
        check("table left_count", lc8, 2);
        check("table right_count", rc8, 2);
        check("table err_count", ec8, 3);
        check("table w2 err_count", ec2, 3);

        // Strobe every 4th cycle, lamps held between strobes
        ld_seen = 0; err_seen = 0;
        for (int s = 0; s < 4; s++) begin
            logic [2:0] pat;
            pat = (s == 0) ? 3'b100 : (s == 1) ? 3'b110 : (s == 2) ? 3'b111 : 3'b000;
            for (int k = 0; k < 4; k++)
                apply(k == 0, pat, 3'b000);
        end
        check("strobe left_done pulses", ld_seen, 1);
        check("strobe errors", err_seen, 0);

        // Asynchronous reset in the middle of L2
        apply(1, 3'b100, 3'b000);
        apply(1, 3'b110, 3'b000);
        check("pre-reset dir", dir8, 2'b01);
        #2 reset = 1'b0;
        #1;
        check_zero("mid-L2 reset");
        model_reset();
        release_reset();
        apply(1, 3'b000, 3'b000);

        // Five left sequences: 2-bit counter sticks at 3
        ld_seen = 0;
        for (int n = 0; n < 5; n++) begin
            apply(1, 3'b100, 3'b000);
            apply(1, 3'b110, 3'b000);
            apply(1, 3'b111, 3'b000);
            apply(1, 3'b000, 3'b000);
        end
        check("sat left_done pulses", ld_seen, 5);
        check("sat w2 left_count", lc2, 3);
        check("sat w8 left_count", lc8, 5);

        // Random traffic, biased towards legal progressions
        for (int n = 0; n < 1500; n++) begin
            logic       en;
            logic [2:0] l, r;
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) != 0) begin
                int side, stp;
                side = (m_side == 0) ? int'($urandom_range(1, 2)) : m_side;
                stp  = (m_step == 3) ? 0 : m_step + 1;
                l = 3'b000; r = 3'b000;
                if (stp != 0) begin
                    logic [2:0] lit;
                    lit = (stp == 1) ? 3'b100 : (stp == 2) ? 3'b110 : 3'b111;
                    if (side == 1) l = lit; else r = lit;
                end
            end else begin
                l = 3'($urandom_range(0, 7));
                r = 3'($urandom_range(0, 7));
            end
            apply(en, l, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
